// File: rtl/multi_seq_mul.sv
// multi_seq_mul
// -----------------------------------------------------------------------------
// Sequenced shift-multiply unit. Accepts one DW-bit unsigned sample through a
// valid/ready handshake and emits up to NCOEF products sample * coef[k], one
// per output beat, honouring downstream backpressure. Coefficients live in a
// runtime-programmable table. The whole table is snapshotted when a sample is
// accepted, so table writes never disturb a sequence that is already running.
// Reset contents reproduce the legacy 1/4/7/8 sequence.
//
// Optional feature macro: MULTI_SEQ_MUL_SAT_EN
//   defined   : products wider than OW saturate to 2^OW-1; adds out_sat.
//   undefined : products are truncated to their OW LSBs; no out_sat port.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   sample offered
//   in_ready   out  sample can be accepted this cycle
//   in_data    in   [DW-1:0] sample
//   seq_len    in   beats for this sample (0 or >NCOEF means NCOEF)
//   cfg_we     in   coefficient write strobe
//   cfg_addr   in   coefficient index (out-of-range writes ignored)
//   cfg_data   in   [CW-1:0] coefficient value
//   out_valid  out  out_data holds a valid product
//   out_ready  in   consumer accepts the current beat
//   out_data   out  [OW-1:0] product
//   out_idx    out  beat index k
//   out_sat    out  current beat saturated (MULTI_SEQ_MUL_SAT_EN only)
//   out_last   out  final beat of the current sample
// -----------------------------------------------------------------------------
module multi_seq_mul #(
  parameter int unsigned         DW        = 8,
  parameter int unsigned         CW        = 4,
  parameter int unsigned         NCOEF     = 4,
  parameter int unsigned         OW        = 12,
  parameter logic [NCOEF*CW-1:0] COEF_INIT = {4'd8, 4'd7, 4'd4, 4'd1}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic [$clog2(NCOEF+1)-1:0] seq_len,
  input  logic                       cfg_we,
  input  logic [$clog2(NCOEF)-1:0]   cfg_addr,
  input  logic [CW-1:0]              cfg_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OW-1:0]              out_data,
  output logic [$clog2(NCOEF)-1:0]   out_idx,
`ifdef MULTI_SEQ_MUL_SAT_EN
  output logic                       out_sat,
`endif
  output logic                       out_last
);

  localparam int unsigned LW = $clog2(NCOEF + 1);
  localparam int unsigned AW = $clog2(NCOEF);
  localparam int unsigned PW = DW + CW;
  // Comparison width wide enough for both the full product and the OW limit.
  localparam int unsigned MW = (OW > PW) ? OW : PW;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // ---------------------------------------------------------------------------
  // Product narrowing
  // ---------------------------------------------------------------------------
  // Narrow a full-precision product to OW bits. When OW >= PW the cast simply
  // zero-extends, so both builds agree in that case.
  function automatic logic [OW-1:0] f_narrow(input logic [PW-1:0] p);
`ifdef MULTI_SEQ_MUL_SAT_EN
    if (MW'(p) > MW'({OW{1'b1}})) return {OW{1'b1}};
`endif
    return OW'(p);
  endfunction

`ifdef MULTI_SEQ_MUL_SAT_EN
  function automatic logic f_is_sat(input logic [PW-1:0] p);
    return MW'(p) > MW'({OW{1'b1}});
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          r_state;
  logic [DW-1:0]   r_sample;
  logic [LW-1:0]   r_len;
  logic [CW-1:0]   r_tab  [NCOEF];
  logic [CW-1:0]   r_snap [NCOEF];
  logic            r_out_valid;
  logic [OW-1:0]   r_out_data;
  logic [AW-1:0]   r_out_idx;
  logic            r_out_last;
`ifdef MULTI_SEQ_MUL_SAT_EN
  logic            r_out_sat;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic            w_in_ready;
  logic            w_accept;
  logic            w_beat_done;
  logic [LW-1:0]   w_len;
  logic [AW-1:0]   w_next_idx;
  logic [PW-1:0]   w_prod0;
  logic [PW-1:0]   w_prod_nx;
  logic            w_cfg_hit;

  // The last beat being consumed frees the unit in the same cycle, which is
  // what lets back-to-back samples flow without a bubble.
  assign w_beat_done = r_out_valid && out_ready;
  assign w_in_ready  = (r_state == StIdle) || (w_beat_done && r_out_last);
  assign w_accept    = in_valid && w_in_ready;

  // Zero or an over-range request both mean "full table".
  assign w_len = ((seq_len == '0) || (32'(seq_len) > 32'(NCOEF))) ? LW'(NCOEF) : seq_len;

  assign w_next_idx = r_out_idx + AW'(1);

  // Beat 0 of a newly accepted sample reads the live table: it equals the
  // snapshot taken at the same edge, and a same-cycle write is not yet visible.
  assign w_prod0   = PW'(in_data) * PW'(r_tab[0]);
  assign w_prod_nx = PW'(r_sample) * PW'(r_snap[w_next_idx]);

  assign w_cfg_hit = cfg_we && (32'(cfg_addr) < 32'(NCOEF));

  // ---------------------------------------------------------------------------
  // Coefficient table
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(NCOEF); k++) begin
        r_tab[k] <= COEF_INIT[k*CW +: CW];
      end
    end else if (w_cfg_hit) begin
      r_tab[cfg_addr] <= cfg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_sample    <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
`ifdef MULTI_SEQ_MUL_SAT_EN
      r_out_sat   <= 1'b0;
`endif
      for (int k = 0; k < int'(NCOEF); k++) begin
        r_snap[k] <= COEF_INIT[k*CW +: CW];
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state     <= StRun;
            r_sample    <= in_data;
            r_len       <= w_len;
            r_snap      <= r_tab;
            r_out_valid <= 1'b1;
            r_out_idx   <= '0;
            r_out_data  <= f_narrow(w_prod0);
            r_out_last  <= (w_len == LW'(1));
`ifdef MULTI_SEQ_MUL_SAT_EN
            r_out_sat   <= f_is_sat(w_prod0);
`endif
          end
        end
        StRun: begin
          if (w_accept) begin
            // Last beat consumed and a new sample taken in the same cycle.
            r_sample    <= in_data;
            r_len       <= w_len;
            r_snap      <= r_tab;
            r_out_valid <= 1'b1;
            r_out_idx   <= '0;
            r_out_data  <= f_narrow(w_prod0);
            r_out_last  <= (w_len == LW'(1));
`ifdef MULTI_SEQ_MUL_SAT_EN
            r_out_sat   <= f_is_sat(w_prod0);
`endif
          end else if (w_beat_done) begin
            if (r_out_last) begin
              r_state     <= StIdle;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_out_idx   <= w_next_idx;
              r_out_data  <= f_narrow(w_prod_nx);
              r_out_last  <= (LW'(w_next_idx) == (r_len - LW'(1)));
`ifdef MULTI_SEQ_MUL_SAT_EN
              r_out_sat   <= f_is_sat(w_prod_nx);
`endif
            end
          end
          // Otherwise stalled: all outputs hold.
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
`ifdef MULTI_SEQ_MUL_SAT_EN
  assign out_sat   = r_out_sat;
`endif

endmodule

// File: tb/tb_multi_seq_mul.sv
// Directed-vector bench for multi_seq_mul. A default instance (OW=12) and a
// narrow instance (OW=10) share every input; expected values are hand-computed.
module tb_multi_seq_mul;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  seq_len;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;

  logic        n_in_ready;
  logic        n_out_valid;
  logic [9:0]  n_out_data;
  logic [1:0]  n_out_idx;
  logic        n_out_last;
`ifdef MULTI_SEQ_MUL_SAT_EN
  logic        out_sat;
  logic        n_out_sat;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  multi_seq_mul u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .seq_len   (seq_len),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
`ifdef MULTI_SEQ_MUL_SAT_EN
    .out_sat   (out_sat),
`endif
    .out_last  (out_last)
  );

  multi_seq_mul #(.OW(10)) u_nar (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (n_in_ready),
    .in_data   (in_data),
    .seq_len   (seq_len),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .out_valid (n_out_valid),
    .out_ready (out_ready),
    .out_data  (n_out_data),
    .out_idx   (n_out_idx),
`ifdef MULTI_SEQ_MUL_SAT_EN
    .out_sat   (n_out_sat),
`endif
    .out_last  (n_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; seq_len = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
    #3;
    n_tests++;
    if ({out_valid, out_data, out_idx, out_last} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b d=%0d i=%0d l=%0b, want all 0",
               out_valid, out_data, out_idx, out_last);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_default_seq();
    logic [11:0] exp [4];
    exp[0] = 12'd10; exp[1] = 12'd40; exp[2] = 12'd70; exp[3] = 12'd80;
    tick();
    in_valid = 1'b1; in_data = 8'd10; seq_len = 3'd0;
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b == 0) in_valid = 1'b0;
      n_tests++;
      if ({out_valid, out_data, out_idx, out_last} !==
          {1'b1, exp[b], 2'(b), (b == 3)}) begin
        n_fail++;
        $display("FAIL default_beat%0d: got v=%0b d=%0d i=%0d l=%0b, want d=%0d i=%0d l=%0b",
                 b, out_valid, out_data, out_idx, out_last, exp[b], b, (b == 3));
      end
      n_tests++;
      if (in_ready !== (b == 3)) begin
        n_fail++;
        $display("FAIL default_in_ready%0d: got %0b want %0b", b, in_ready, (b == 3));
      end
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL default_end_valid: got %0b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp [8];
    exp[0] = 12'd3; exp[1] = 12'd12; exp[2] = 12'd21; exp[3] = 12'd24;
    exp[4] = 12'd5; exp[5] = 12'd20; exp[6] = 12'd35; exp[7] = 12'd40;
    in_valid = 1'b1; in_data = 8'd3; seq_len = 3'd0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_tests++;
      if ({out_valid, out_data, out_idx} !== {1'b1, exp[c], 2'(c % 4)}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got v=%0b d=%0d i=%0d, want v=1 d=%0d i=%0d",
                 c, out_valid, out_data, out_idx, exp[c], c % 4);
      end
      if (c == 0) in_data = 8'd5;
      if (c == 4) in_valid = 1'b0;
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end_valid: got %0b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 8'd9; seq_len = 3'd0;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_tests++;
      if ({out_valid, out_data, out_idx, out_last} !== {1'b1, 12'd36, 2'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%0b d=%0d i=%0d l=%0b, want v=1 d=36 i=1 l=0",
                 s, out_valid, out_data, out_idx, out_last);
      end
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_in_ready: got %0b want 0", in_ready);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if ({out_data, out_idx} !== {12'd63, 2'd2}) begin
      n_fail++;
      $display("FAIL resume_beat2: got d=%0d i=%0d want d=63 i=2", out_data, out_idx);
    end
    tick();
    n_tests++;
    if ({out_data, out_idx, out_last} !== {12'd72, 2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL resume_beat3: got d=%0d i=%0d l=%0b want d=72 i=3 l=1",
               out_data, out_idx, out_last);
    end
    tick();
  endtask

  // Runs one sample of value 2 with full length and checks the four beats.
  task automatic run_two(input string tag, input logic [11:0] c2, input bit do_write);
    logic [11:0] exp [4];
    exp[0] = 12'd2; exp[1] = 12'd8; exp[2] = c2; exp[3] = 12'd16;
    in_valid = 1'b1; in_data = 8'd2; seq_len = 3'd0;
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b == 0) in_valid = 1'b0;
      cfg_we = 1'b0;
      if (b == 1 && do_write) begin
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 4'd15;
      end
      n_tests++;
      if ({out_valid, out_data, out_idx} !== {1'b1, exp[b], 2'(b)}) begin
        n_fail++;
        $display("FAIL %s_beat%0d: got v=%0b d=%0d i=%0d, want d=%0d i=%0d",
                 tag, b, out_valid, out_data, out_idx, exp[b], b);
      end
    end
    cfg_we = 1'b0;
    tick();
  endtask

  task automatic test_program_snapshot();
    run_two("snap_old", 12'd14, 1'b1);
    run_two("snap_new", 12'd30, 1'b0);
  endtask

  task automatic test_len_and_reset();
    in_valid = 1'b1; in_data = 8'd255; seq_len = 3'd2;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, out_data, out_idx, out_last} !== {1'b1, 12'd255, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL len2_beat0: got v=%0b d=%0d i=%0d l=%0b, want d=255 i=0 l=0",
               out_valid, out_data, out_idx, out_last);
    end
    tick();
    n_tests++;
    if ({out_valid, out_data, out_idx, out_last} !== {1'b1, 12'd1020, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL len2_beat1: got v=%0b d=%0d i=%0d l=%0b, want d=1020 i=1 l=1",
               out_valid, out_data, out_idx, out_last);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL len2_end_valid: got %0b want 0", out_valid);
    end
    // Reset in the middle of a seq_len=4 sample.
    in_valid = 1'b1; in_data = 8'd1; seq_len = 3'd4;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_data, out_idx, out_last} !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%0b d=%0d i=%0d l=%0b, want all 0",
               out_valid, out_data, out_idx, out_last);
    end
    #2;
    rst = 1'b1;
    // coef[2] was programmed to 15; after reset it must be back to 7.
    run_two("post_reset", 12'd14, 1'b0);
  endtask

  task automatic test_narrow();
    logic [9:0] exp [4];
    logic       exp_sat [4];
    exp[0] = 10'd255; exp[1] = 10'd1020;
`ifdef MULTI_SEQ_MUL_SAT_EN
    exp[2] = 10'd1023; exp[3] = 10'd1023;
`else
    exp[2] = 10'd761;  exp[3] = 10'd1016;
`endif
    exp_sat[0] = 1'b0; exp_sat[1] = 1'b0; exp_sat[2] = 1'b1; exp_sat[3] = 1'b1;
    in_valid = 1'b1; in_data = 8'd255; seq_len = 3'd0;
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b == 0) in_valid = 1'b0;
      n_tests++;
      if ({n_out_valid, n_out_data, n_out_idx, n_out_last} !==
          {1'b1, exp[b], 2'(b), (b == 3)}) begin
        n_fail++;
        $display("FAIL narrow_beat%0d: got v=%0b d=%0d i=%0d l=%0b, want d=%0d i=%0d",
                 b, n_out_valid, n_out_data, n_out_idx, n_out_last, exp[b], b);
      end
`ifdef MULTI_SEQ_MUL_SAT_EN
      n_tests++;
      if (n_out_sat !== exp_sat[b]) begin
        n_fail++;
        $display("FAIL narrow_sat%0d: got %0b want %0b", b, n_out_sat, exp_sat[b]);
      end
      n_tests++;
      if (out_sat !== 1'b0) begin
        n_fail++;
        $display("FAIL wide_sat%0d: got %0b want 0", b, out_sat);
      end
`else
      if (b == 3 && exp_sat[b] !== 1'b1) $display("note: unexpected table");
`endif
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_default_seq();
    test_back_to_back();
    test_backpressure();
    test_program_snapshot();
    test_len_and_reset();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
